// File: rtl/fht_twiddle_gen_if.sv
// Sweep request / twiddle-pair bus between stage controller and twiddle generator.
// Latency: none (wires only).
// Backpressure: iHOLD from the consumer freezes the generator; no ready/credit path.
interface fht_twiddle_gen_if #(
   parameter int W_BIT = 12,
   parameter int N_BIT = 8
);
   logic                    iSTART;
   logic [N_BIT-1:0]        iBASE;
   logic [N_BIT-1:0]        iSTEP;
   logic [N_BIT:0]          iCOUNT;
   logic                    iHOLD;
   logic                    oBUSY;
   logic                    oVALID;
   logic signed [W_BIT-1:0] oSIN;
   logic signed [W_BIT-1:0] oCOS;
   logic [N_BIT-1:0]        oINDEX;
   logic                    oLAST;

   // stage controller / butterfly side
   modport master (
      output iSTART, iBASE, iSTEP, iCOUNT, iHOLD,
      input  oBUSY, oVALID, oSIN, oCOS, oINDEX, oLAST
   );

   // twiddle generator side
   modport slave (
      input  iSTART, iBASE, iSTEP, iCOUNT, iHOLD,
      output oBUSY, oVALID, oSIN, oCOS, oINDEX, oLAST
   );
endinterface

// File: rtl/fht_twiddle_gen.sv
// Twiddle generator: quarter-wave sine table + quadrant fold, driven by a base/step/count sweep.
// Latency: first pair visible 2 edges after the start edge, then one pair per non-held clock.
// Backpressure: iHOLD=1 freezes sequencer, ROM registers and outputs; nothing is skipped or repeated.
module fht_twiddle_gen #(
   parameter int W_BIT = 12,
   parameter int N_BIT = 8,
   parameter     MIF   = "./matlab/sin_q.mif"
) (
   input logic          iCLK,
   input logic          iRESET,
   fht_twiddle_gen_if.slave bus
);

   localparam int               Q      = 1 << (N_BIT-2);
   localparam logic [N_BIT-2:0] Q_ADR  = Q[N_BIT-2:0];
   localparam logic [N_BIT:0]   REM_ONE = 1;

   // fixed-point constants used to build the table at elaboration (scale 2^30)
   localparam longint FS   = (64'sd1 <<< (W_BIT-1)) - 64'sd1;
   localparam longint ONE  = 64'sd1 <<< 30;
   localparam longint PI_S = 64'sd3373259426;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // T[j] = round(FS * sin(2*pi*j/N)), the same contents the MIF file carries; the
   // table is evaluated here with a Taylor series so no file is needed at build time.
   function automatic longint quarter_sin(input int j);
      longint x, term, acc;
      x    = (PI_S * longint'(j)) / longint'(2*Q);
      term = x;
      acc  = x;
      for (int n = 1; n < 10; n++) begin
         term = -((((term * x) / ONE) * x) / ONE) / longint'((2*n) * (2*n+1));
         acc  = acc + term;
      end
      return (acc * FS + ONE/2) / ONE;
   endfunction

   logic [W_BIT-1:0] tbl [0:Q];

   for (genvar j = 0; j <= Q; j++) begin : g_tbl
      localparam longint TV = quarter_sin(j);
      assign tbl[j] = TV[W_BIT-1:0];
   end

   // sequencer state; k is pipeline stage S0
   logic [1:0]       state;
   logic [N_BIT-1:0] k;
   logic [N_BIT-1:0] step;
   logic [N_BIT:0]   rem;

   // stage S1: ROM outputs with quadrant, index and tags
   logic             s1_vld;
   logic             s1_last;
   logic [1:0]       s1_q;
   logic [N_BIT-1:0] s1_k;
   logic [W_BIT-1:0] s1_a;
   logic [W_BIT-1:0] s1_b;

   // stage S2: output registers
   logic             o_vld;
   logic             o_last;
   logic [N_BIT-1:0] o_idx;
   logic [W_BIT-1:0] o_sin;
   logic [W_BIT-1:0] o_cos;

   logic             run;
   logic             issue_last;
   logic [N_BIT-2:0] adr_a;
   logic [N_BIT-2:0] adr_b;
   logic [W_BIT-1:0] sin_n;
   logic [W_BIT-1:0] cos_n;

   assign run        = (state == ST_RUN);
   assign issue_last = run && (rem == REM_ONE);
   assign adr_a      = {1'b0, k[N_BIT-3:0]};
   assign adr_b      = Q_ADR - adr_a;

   // sweep sequencer: accept a start in IDLE, step k each RUN edge, wait for last transfer in DRAIN
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state <= ST_IDLE;
         k     <= '0;
         step  <= '0;
         rem   <= '0;
      end else if (!bus.iHOLD) begin
         case (state)
            ST_IDLE: begin
               if (bus.iSTART && (bus.iCOUNT != '0)) begin
                  k     <= bus.iBASE;
                  step  <= bus.iSTEP;
                  rem   <= bus.iCOUNT;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               k   <= k + step;
               rem <= rem - REM_ONE;
               if (rem == REM_ONE) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (o_vld && o_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // S1: synchronous reads of T[r] and T[Q-r] alongside the issued index
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
         s1_q    <= '0;
         s1_k    <= '0;
         s1_a    <= '0;
         s1_b    <= '0;
      end else if (!bus.iHOLD) begin
         s1_vld  <= run;
         s1_last <= issue_last;
         s1_q    <= k[N_BIT-1:N_BIT-2];
         s1_k    <= k;
         s1_a    <= tbl[adr_a];
         s1_b    <= tbl[adr_b];
      end
   end

   // quadrant fold: swap T[r]/T[Q-r] and negate per quadrant (table max keeps -x in range)
   always_comb begin
      sin_n = s1_a;
      cos_n = s1_b;
      case (s1_q)
         2'd0: begin sin_n =  s1_a; cos_n =  s1_b; end
         2'd1: begin sin_n =  s1_b; cos_n = -s1_a; end
         2'd2: begin sin_n = -s1_a; cos_n = -s1_b; end
         2'd3: begin sin_n = -s1_b; cos_n =  s1_a; end
         default: ;
      endcase
   end

   // S2: output registers
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         o_vld  <= 1'b0;
         o_last <= 1'b0;
         o_idx  <= '0;
         o_sin  <= '0;
         o_cos  <= '0;
      end else if (!bus.iHOLD) begin
         o_vld  <= s1_vld;
         o_last <= s1_vld && s1_last;
         o_idx  <= s1_k;
         o_sin  <= sin_n;
         o_cos  <= cos_n;
      end
   end

   assign bus.oBUSY  = (state != ST_IDLE);
   assign bus.oVALID = o_vld;
   assign bus.oLAST  = o_last;
   assign bus.oINDEX = o_idx;
   assign bus.oSIN   = o_sin;
   assign bus.oCOS   = o_cos;

endmodule

// File: tb/tb_fht_twiddle_gen.sv
// Bench for fht_twiddle_gen: directed + randomized sweeps against a real-math sin/cos model.
// Latency: scoreboard checks order/values; start-to-first-pair and busy length checked directly.
// Backpressure: iHOLD toggled randomly and in fixed windows; held outputs must not move.
module tb_fht_twiddle_gen;
   localparam int  W   = 12;
   localparam int  NB  = 8;
   localparam int  N   = 256;
   localparam int  FSV = 2047;
   localparam real PI  = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fht_twiddle_gen_if #(.W_BIT(W), .N_BIT(NB)) bus ();

   fht_twiddle_gen #(.W_BIT(W), .N_BIT(NB)) dut (
      .iCLK   (clk),
      .iRESET (rst),
      .bus    (bus)
   );

   typedef struct { int idx; int s; int c; bit last; } exp_t;
   exp_t sbq[$];

   int checks   = 0;
   int failures = 0;
   int pops     = 0;

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(0.5 - x);
   endfunction

   function automatic int ref_sin(input int k);
      return rnd(FSV * $sin(2.0 * PI * k / N));
   endfunction

   function automatic int ref_cos(input int k);
      return rnd(FSV * $cos(2.0 * PI * k / N));
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sweep(input int b, input int s, input int c);
      exp_t e;
      for (int i = 0; i < c; i++) begin
         e.idx  = (b + i * s) % N;
         e.s    = ref_sin(e.idx);
         e.c    = ref_cos(e.idx);
         e.last = (i == c - 1);
         sbq.push_back(e);
      end
   endtask

   // caller sits just after a rising edge; the start is taken on the next edge
   task automatic issue(input int b, input int s, input int c);
      bus.iHOLD   = 1'b0;
      bus.iBASE   = b[NB-1:0];
      bus.iSTEP   = s[NB-1:0];
      bus.iCOUNT  = c[NB:0];
      bus.iSTART  = 1'b1;
      push_sweep(b, s, c);
      sync();
      bus.iSTART  = 1'b0;
   endtask

   task automatic issue_timed(input int b, input int s, input int c,
                              input bit chk_sc, input int esin, input int ecos);
      int busy_cyc;
      busy_cyc = 0;
      issue(b, s, c);
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (n < 2) check("lat_early_valid", int'(bus.oVALID), 0);
         if (n == 2) begin
            check("lat_valid", int'(bus.oVALID), 1);
            check("lat_index", int'(bus.oINDEX), b);
            if (chk_sc) begin
               check("lat_sin", int'(bus.oSIN), esin);
               check("lat_cos", int'(bus.oCOS), ecos);
            end
         end
         if (!bus.oBUSY) break;
         busy_cyc++;
      end
      check("busy_cycles", busy_cyc, c + 2);
      sync();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!bus.oBUSY) break;
         sync();
      end
      check("idle_timeout", int'(bus.oBUSY), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, int'(bus.oVALID), 0);
      check({tag, "_busy"},  int'(bus.oBUSY), 0);
      check({tag, "_sin"},   int'(bus.oSIN), 0);
      check({tag, "_cos"},   int'(bus.oCOS), 0);
      check({tag, "_index"}, int'(bus.oINDEX), 0);
      check({tag, "_last"},  int'(bus.oLAST), 0);
   endtask

   // monitor: pops the scoreboard on every transfer, and checks that held cycles keep outputs
   bit   held_prev = 1'b0;
   int   sv, ss, sc, si, sl;
   exp_t me;
   always @(negedge clk) begin
      if (rst) begin
         held_prev = 1'b0;
      end else begin
         if (held_prev) begin
            check("hold_frozen_valid", int'(bus.oVALID), sv);
            check("hold_frozen_sin",   int'(bus.oSIN),   ss);
            check("hold_frozen_cos",   int'(bus.oCOS),   sc);
            check("hold_frozen_index", int'(bus.oINDEX), si);
            check("hold_frozen_last",  int'(bus.oLAST),  sl);
         end
         if (bus.oVALID && !bus.iHOLD) begin
            if (sbq.size() == 0) begin
               check("sb_unexpected_pair", int'(bus.oINDEX), -1);
            end else begin
               me = sbq.pop_front();
               check("sb_index", int'(bus.oINDEX), me.idx);
               check("sb_sin",   int'(bus.oSIN),   me.s);
               check("sb_cos",   int'(bus.oCOS),   me.c);
               check("sb_last",  int'(bus.oLAST),  int'(me.last));
               pops++;
            end
         end
         held_prev = bus.iHOLD;
         sv = int'(bus.oVALID);
         ss = int'(bus.oSIN);
         sc = int'(bus.oCOS);
         si = int'(bus.oINDEX);
         sl = int'(bus.oLAST);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   int card_b [4] = '{0, 64, 128, 192};
   int card_s [4] = '{0, 2047, 0, -2047};
   int card_c [4] = '{2047, 0, -2047, 0};

   initial begin
      int p0, rb, rs, rc;
      rst        = 1'b1;
      bus.iSTART = 1'b0;
      bus.iBASE  = '0;
      bus.iSTEP  = '0;
      bus.iCOUNT = '0;
      bus.iHOLD  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;
      sync();

      // count of zero is a no-op
      issue(7, 1, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("count0_busy", int'(bus.oBUSY), 0);
      end
      sync();

      // cardinal angles, single-pair sweeps
      for (int i = 0; i < 4; i++)
         issue_timed(card_b[i], 1, 1, 1'b1, card_s[i], card_c[i]);

      // wrap across N; index 250 folds to -T[6] / T[58]
      issue_timed(250, 3, 4, 1'b1, -ref_sin(6), ref_sin(58));

      // full sweep with a hold window mid-sweep and another during drain
      issue(0, 1, 256);
      repeat (99) sync();
      bus.iHOLD = 1'b1;
      repeat (3) sync();
      bus.iHOLD = 1'b0;
      repeat (157) sync();
      check("drain_busy", int'(bus.oBUSY), 1);
      bus.iHOLD = 1'b1;
      repeat (3) sync();
      bus.iHOLD = 1'b0;
      wait_idle(50);
      check("full_sweep_pops", pops, 4 + 4 + 256);

      // start requests while busy are ignored; restart on the edge after busy falls
      issue(10, 7, 20);
      repeat (5) sync();
      bus.iSTART = 1'b1;
      bus.iBASE  = 8'd99;
      bus.iSTEP  = 8'd1;
      bus.iCOUNT = 9'd5;
      sync();
      bus.iSTART = 1'b0;
      check("reject_busy", int'(bus.oBUSY), 1);
      for (int i = 0; i < 100; i++) begin
         if (!bus.oBUSY) break;
         sync();
      end
      issue_timed(40, 1, 3, 1'b0, 0, 0);

      // randomized sweeps with random hold
      for (int r = 0; r < 8; r++) begin
         rb = int'($urandom_range(0, 255));
         rs = int'($urandom_range(0, 255));
         rc = int'($urandom_range(1, 48));
         issue(rb, rs, rc);
         for (int i = 0; i < 400; i++) begin
            if (!bus.oBUSY) break;
            bus.iHOLD = ($urandom_range(0, 3) == 0);
            sync();
         end
         bus.iHOLD = 1'b0;
         wait_idle(50);
      end
      check("random_drained", sbq.size(), 0);

      // asynchronous reset mid-sweep, then a clean short sweep
      issue(0, 1, 50);
      p0 = pops;
      for (int i = 0; i < 100; i++) begin
         if (pops - p0 >= 10) break;
         sync();
      end
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_reset");
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("held_reset");
      rst = 1'b0;
      issue_timed(5, 1, 2, 1'b0, 0, 0);
      repeat (4) sync();
      check("final_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
